// File: rtl/status_classifier.sv
// -----------------------------------------------------------------------------
// status_classifier
//
// Converts a stream of unsigned sensor samples into a 2-bit system status:
//   0 = NORMAL, 1 = BORDERLINE, 2 = ATTENTION, 3 = EMERGENCY.
// Each accepted sample is classified against three thresholds. Once a level is
// reached, the sample only has to stay above (threshold - HYST) to keep it. A
// new level is adopted only after CONFIRM consecutive accepted samples agree
// on it. EMERGENCY latches: samples are ignored until an operator ack returns
// the block to NORMAL and clears the peak tracker.
//
// Ports
//   clk           in   1      rising-edge clock
//   rst_n         in   1      asynchronous active-low reset
//   sample        in   WIDTH  unsigned sensor reading
//   sample_valid  in   1      sample is accepted on this edge when high
//   ack           in   1      one-cycle operator acknowledge (used only in EMERGENCY)
//   state         out  2      current status code
//   changed       out  1      one-cycle pulse when state has just been updated
//   alarm         out  1      registered, high while state is EMERGENCY
//   peak          out  WIDTH  largest accepted sample since reset or last ack
// -----------------------------------------------------------------------------
module status_classifier #(
   parameter int WIDTH    = 8,
   parameter int T_BORDER = 100,
   parameter int T_ATTN   = 150,
   parameter int T_EMERG  = 200,
   parameter int HYST     = 5,
   parameter int CONFIRM  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sample,
   input  logic             sample_valid,
   input  logic             ack,
   output logic [1:0]       state,
   output logic             changed,
   output logic             alarm,
   output logic [WIDTH-1:0] peak
);

   typedef enum logic [1:0] {
      NORMAL     = 2'd0,
      BORDERLINE = 2'd1,
      ATTENTION  = 2'd2,
      EMERGENCY  = 2'd3
   } status_t;

   localparam int CW = (CONFIRM < 1) ? 1 : $clog2(CONFIRM + 1);
   localparam logic [CW-1:0] CONFIRM_C = CW'(CONFIRM);

   status_t          state_reg, state_next;
   logic [1:0]       pend_reg, pend_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [WIDTH-1:0] peak_reg, peak_next;
   logic             changed_reg, changed_next;
   logic             alarm_reg, alarm_next;

   // One extra bit so thresholds at or above 2**WIDTH never wrap.
   logic [WIDTH:0] sample_ext;
   assign sample_ext = {1'b0, sample};

   // crossed[k]: sample reaches level k, either outright or, when the current
   // state is already at or above k, within the hysteresis band below T_k.
   logic [3:1] crossed;

   for (genvar gi = 1; gi <= 3; gi++) begin : g_level
      localparam int             THR  = (gi == 3) ? T_EMERG : ((gi == 2) ? T_ATTN : T_BORDER);
      localparam logic [WIDTH:0] T_HI = (WIDTH + 1)'(THR);
      localparam logic [WIDTH:0] T_LO = (WIDTH + 1)'(THR - HYST);
      localparam logic [1:0]     K    = 2'(gi);
      assign crossed[gi] = (sample_ext >= T_HI) ||
                           ((state_reg >= K) && (sample_ext >= T_LO));
   end

   // Highest crossed level wins.
   logic [1:0] lvl;
   always_comb begin
      lvl = 2'd0;
      if (crossed[3])      lvl = 2'd3;
      else if (crossed[2]) lvl = 2'd2;
      else if (crossed[1]) lvl = 2'd1;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= NORMAL;
         pend_reg    <= 2'd0;
         cnt_reg     <= '0;
         peak_reg    <= '0;
         changed_reg <= 1'b0;
         alarm_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pend_reg    <= pend_next;
         cnt_reg     <= cnt_next;
         peak_reg    <= peak_next;
         changed_reg <= changed_next;
         alarm_reg   <= alarm_next;
      end
   end

   // Next-state logic
   logic [CW-1:0] cnt_new;

   always_comb begin
      state_next   = state_reg;
      pend_next    = pend_reg;
      cnt_next     = cnt_reg;
      peak_next    = peak_reg;
      changed_next = 1'b0;
      cnt_new      = '0;

      if (state_reg == EMERGENCY) begin
         // Latched: samples are dropped, only ack releases (even if a sample
         // arrives on the same edge).
         if (ack) begin
            state_next   = NORMAL;
            pend_next    = 2'd0;
            cnt_next     = '0;
            peak_next    = '0;
            changed_next = 1'b1;
         end
      end else if (sample_valid) begin
         if (sample > peak_reg) begin
            peak_next = sample;
         end

         if (lvl == state_reg) begin
            // Sample agrees with the current state: any pending streak ends.
            pend_next = state_reg;
            cnt_next  = '0;
         end else begin
            // Streak continues only while the candidate level is unchanged;
            // cnt never exceeds CONFIRM-1 here, so +1 cannot overflow.
            cnt_new   = (lvl == pend_reg) ? (cnt_reg + 1'b1) : CW'(1);
            pend_next = lvl;
            if (cnt_new == CONFIRM_C) begin
               state_next   = status_t'(lvl);
               cnt_next     = '0;
               changed_next = 1'b1;
            end else begin
               cnt_next = cnt_new;
            end
         end
      end

      alarm_next = (state_next == EMERGENCY);
   end

   assign state   = state_reg;
   assign changed = changed_reg;
   assign alarm   = alarm_reg;
   assign peak    = peak_reg;

endmodule

// File: tb/tb_status_classifier.sv
// -----------------------------------------------------------------------------
// tb_status_classifier
//
// Directed scenarios followed by randomized traffic. Every cycle the DUT
// outputs are compared against a behavioural model that tracks status,
// candidate level, streak length and peak as plain integers.
// -----------------------------------------------------------------------------
module tb_status_classifier;

   localparam int WIDTH    = 8;
   localparam int T_BORDER = 100;
   localparam int T_ATTN   = 150;
   localparam int T_EMERG  = 200;
   localparam int HYST     = 5;
   localparam int CONFIRM  = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] sample;
   logic             sample_valid;
   logic             ack;
   logic [1:0]       state;
   logic             changed;
   logic             alarm;
   logic [WIDTH-1:0] peak;

   status_classifier #(
      .WIDTH(WIDTH), .T_BORDER(T_BORDER), .T_ATTN(T_ATTN),
      .T_EMERG(T_EMERG), .HYST(HYST), .CONFIRM(CONFIRM)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .sample(sample),
      .sample_valid(sample_valid),
      .ack(ack),
      .state(state),
      .changed(changed),
      .alarm(alarm),
      .peak(peak)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int txn    = 0;

   // Reference model
   int thr [4] = '{0, T_BORDER, T_ATTN, T_EMERG};
   int m_state, m_pend, m_streak, m_peak, m_changed;

   function automatic int level_of(input int s, input int st);
      int l;
      l = 0;
      for (int k = 1; k <= 3; k++) begin
         if (s >= thr[k] || (st >= k && s >= thr[k] - HYST)) l = k;
      end
      return l;
   endfunction

   task automatic model_reset();
      m_state = 0; m_pend = 0; m_streak = 0; m_peak = 0; m_changed = 0;
   endtask

   task automatic model_step(input bit v, input int s, input bit a);
      int l;
      m_changed = 0;
      if (m_state == 3) begin
         if (a) begin
            m_state = 0; m_pend = 0; m_streak = 0; m_peak = 0; m_changed = 1;
         end
      end else if (v) begin
         if (s > m_peak) m_peak = s;
         l = level_of(s, m_state);
         if (l == m_state) begin
            m_pend = l;
            m_streak = 0;
         end else begin
            if (l == m_pend) m_streak = m_streak + 1;
            else begin
               m_pend = l;
               m_streak = 1;
            end
            if (m_streak >= CONFIRM) begin
               m_state = l;
               m_streak = 0;
               m_changed = 1;
            end
         end
      end
   endtask

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string ctx);
      check_eq({ctx, ".state"},   int'(state),   m_state);
      check_eq({ctx, ".changed"}, int'(changed), m_changed);
      check_eq({ctx, ".alarm"},   int'(alarm),   (m_state == 3) ? 1 : 0);
      check_eq({ctx, ".peak"},    int'(peak),    m_peak);
   endtask

   // One clock: drive inputs, let the edge happen, update model, compare.
   task automatic step(input bit v, input int s, input bit a);
      sample_valid = v;
      sample       = s[WIDTH-1:0];
      ack          = a;
      @(posedge clk);
      model_step(v, s, a);
      #1;
      txn++;
      $display("txn %0d: valid=%0d sample=%0d ack=%0d -> state=%0d changed=%0d alarm=%0d peak=%0d",
               txn, v, s, a, state, changed, alarm, peak);
      check_outputs("step");
   endtask

   // Asynchronous reset in the middle of a cycle; outputs checked before any edge.
   task automatic apply_reset();
      sample_valid = 1'b0;
      ack          = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      txn++;
      $display("txn %0d: async reset -> state=%0d changed=%0d alarm=%0d peak=%0d",
               txn, state, changed, alarm, peak);
      check_outputs("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
   endtask

   int s_sel, k_sel, smp;

   initial begin
      rst_n        = 1'b0;
      sample_valid = 1'b0;
      ack          = 1'b0;
      sample       = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // BORDERLINE after the third 120, changed for exactly one cycle
      step(1, 120, 0);
      step(1, 120, 0);
      step(1, 120, 0);
      check_eq("t2_state", int'(state), 1);
      check_eq("t2_changed", int'(changed), 1);
      idle(1);
      check_eq("t2_changed_drop", int'(changed), 0);

      // Async reset from a non-reset state, then a broken streak
      apply_reset();
      step(1, 120, 0);
      step(1, 120, 0);
      step(1, 90, 0);
      check_eq("t2b_state", int'(state), 0);

      // Hysteresis around BORDERLINE
      apply_reset();
      for (int i = 0; i < 3; i++) step(1, 120, 0);
      for (int i = 0; i < 3; i++) step(1, 97, 0);
      check_eq("t3_hold", int'(state), 1);
      for (int i = 0; i < 3; i++) step(1, 94, 0);
      check_eq("t3_drop", int'(state), 0);

      // Interrupted escalation, without and with idle gaps
      apply_reset();
      step(1, 160, 0); step(1, 210, 0); step(1, 160, 0); step(1, 160, 0);
      check_eq("t4_before", int'(state), 0);
      step(1, 160, 0);
      check_eq("t4_after", int'(state), 2);
      apply_reset();
      step(1, 160, 0); idle(4);
      step(1, 210, 0); idle(4);
      step(1, 160, 0); idle(4);
      step(1, 160, 0); idle(4);
      check_eq("t4g_before", int'(state), 0);
      step(1, 160, 0);
      check_eq("t4g_after", int'(state), 2);

      // EMERGENCY latch, async reset out of it, latch again, ack release
      apply_reset();
      for (int i = 0; i < 3; i++) step(1, 210, 0);
      check_eq("t5_alarm", int'(alarm), 1);
      check_eq("t5_peak", int'(peak), 210);
      apply_reset();
      for (int i = 0; i < 3; i++) step(1, 210, 0);
      for (int i = 0; i < 10; i++) step(1, 0, 0);
      step(1, 250, 0);
      check_eq("t5_frozen_peak", int'(peak), 210);
      step(1, 250, 1);
      check_eq("t5_ack_state", int'(state), 0);
      check_eq("t5_ack_peak", int'(peak), 0);
      step(0, 0, 1);  // ack outside EMERGENCY is ignored

      // Reset mid-streak loses the streak
      apply_reset();
      step(1, 120, 0);
      step(1, 120, 0);
      apply_reset();
      step(1, 120, 0);
      check_eq("t6_state", int'(state), 0);

      // Randomized traffic concentrated around the thresholds
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            apply_reset();
         end else begin
            s_sel = int'($urandom_range(0, 3));
            if (s_sel == 0) begin
               smp = int'($urandom_range(0, 255));
            end else begin
               k_sel = int'($urandom_range(1, 3));
               smp = thr[k_sel] - 7 + int'($urandom_range(0, 9));
            end
            step($urandom_range(0, 9) < 7, smp, $urandom_range(0, 9) == 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
